rob: RTL and testbench

- Reorder buffer for the P6-style out-of-order core.
- Producer side of the map-table interface:
  - allocates ROB tags at dispatch (`rob_entry_in`);
  - marks entries complete on CDB writeback and reports `rd_wb`;
  - retires in order, driving `commit` / `rd_commit` / `rob_entry_commit` to the map table and the architectural register file.
- Sits between dispatch, the CDB and the register file. Holds speculative results and serves operand values for ready tags.

---
 rtl/rob.sv | 128 ++++++++++++
 tb/tb_rob.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: allocates tags 1..ROB_SIZE at dispatch, completes entries from the CDB,
// and retires in order from the head. Tag 0 is reserved to mean "value lives in the regfile".
module rob #(
  parameter int ROB_SIZE    = 8,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = $clog2(ROB_SIZE + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   dispatch_valid,
  input  logic [4:0]             dispatch_rd,
  output logic [ROB_TAG_LEN-1:0] rob_entry_in,
  output logic                   full,
  output logic                   empty,
  input  logic                   valid_wb,
  input  logic [ROB_TAG_LEN-1:0] rob_entry_wb,
  input  logic [XLEN-1:0]        wb_value,
  output logic [4:0]             rd_wb,
  input  logic [ROB_TAG_LEN-1:0] read_tag1,
  input  logic [ROB_TAG_LEN-1:0] read_tag2,
  output logic [XLEN-1:0]        read_value1,
  output logic [XLEN-1:0]        read_value2,
  output logic                   read_ready1,
  output logic                   read_ready2,
  output logic                   commit,
  output logic [4:0]             rd_commit,
  output logic [ROB_TAG_LEN-1:0] rob_entry_commit,
  output logic [XLEN-1:0]        commit_value
);

  // Storage spans the whole tag space so any tag can index it; slots 0 and
  // those above ROB_SIZE are never allocated and stay not-busy.
  localparam int NTAG = 2 ** ROB_TAG_LEN;
  localparam logic [ROB_TAG_LEN-1:0] LAST = ROB_TAG_LEN'(ROB_SIZE);
  localparam logic [ROB_TAG_LEN-1:0] FIRST = ROB_TAG_LEN'(1);

  logic [NTAG-1:0]        busy;
  logic [NTAG-1:0]        ready;
  logic [4:0]             rd_q    [NTAG];
  logic [XLEN-1:0]        value_q [NTAG];
  logic [ROB_TAG_LEN-1:0] head, tail, count;
  logic                   do_dispatch, do_wb;

  function automatic logic [ROB_TAG_LEN-1:0] next_tag(input logic [ROB_TAG_LEN-1:0] p);
    return (p == LAST) ? FIRST : p + FIRST;
  endfunction

  assign full         = (count == LAST);
  assign empty        = (count == '0);
  assign rob_entry_in = tail;
  assign do_dispatch  = dispatch_valid && !full;
  assign do_wb        = valid_wb && (rob_entry_wb != '0) && busy[rob_entry_wb] && !ready[rob_entry_wb];
  assign rd_wb        = busy[rob_entry_wb] ? rd_q[rob_entry_wb] : '0;

  assign commit           = busy[head] && ready[head] && !flush;
  assign rd_commit        = commit ? rd_q[head] : '0;
  assign rob_entry_commit = commit ? head : '0;
  assign commit_value     = commit ? value_q[head] : '0;

  // Operand lookup: a same-cycle CDB broadcast to a busy tag bypasses the array.
  always_comb begin
    read_ready1 = 1'b0;
    read_value1 = '0;
    if (busy[read_tag1]) begin
      if (valid_wb && rob_entry_wb == read_tag1) begin
        read_ready1 = 1'b1;
        read_value1 = wb_value;
      end else begin
        read_ready1 = ready[read_tag1];
        read_value1 = value_q[read_tag1];
      end
    end
  end

  always_comb begin
    read_ready2 = 1'b0;
    read_value2 = '0;
    if (busy[read_tag2]) begin
      if (valid_wb && rob_entry_wb == read_tag2) begin
        read_ready2 = 1'b1;
        read_value2 = wb_value;
      end else begin
        read_ready2 = ready[read_tag2];
        read_value2 = value_q[read_tag2];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      busy  <= '0;
      ready <= '0;
      for (int unsigned i = 0; i < NTAG; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head  <= FIRST;
      tail  <= FIRST;
      count <= '0;
    end else begin
      // A commit frees the head only when it is busy, so it never collides with
      // the tail slot being allocated (head == tail with busy head means full).
      if (commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= next_tag(head);
      end
      if (do_wb) begin
        ready[rob_entry_wb]   <= 1'b1;
        value_q[rob_entry_wb] <= wb_value;
      end
      if (do_dispatch) begin
        busy[tail]    <= 1'b1;
        ready[tail]   <= 1'b0;
        rd_q[tail]    <= dispatch_rd;
        value_q[tail] <= '0;
        tail          <= next_tag(tail);
      end
      case ({do_dispatch, commit})
        2'b10:   count <= count + FIRST;
        2'b01:   count <= count - FIRST;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a per-cycle vector table of inputs and expected
// pre-edge outputs, followed by a hand-written writeback-to-commit latency sequence.
module tb_rob;

  logic        clock = 1'b0;
  logic        reset, flush, dispatch_valid, valid_wb;
  logic [4:0]  dispatch_rd, rd_wb, rd_commit;
  logic [3:0]  rob_entry_in, rob_entry_wb, read_tag1, read_tag2, rob_entry_commit;
  logic [31:0] wb_value, read_value1, read_value2, commit_value;
  logic        full, empty, read_ready1, read_ready2, commit;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rob #(.ROB_SIZE(8), .XLEN(32), .ROB_TAG_LEN(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd),
    .rob_entry_in(rob_entry_in), .full(full), .empty(empty),
    .valid_wb(valid_wb), .rob_entry_wb(rob_entry_wb), .wb_value(wb_value), .rd_wb(rd_wb),
    .read_tag1(read_tag1), .read_tag2(read_tag2),
    .read_value1(read_value1), .read_value2(read_value2),
    .read_ready1(read_ready1), .read_ready2(read_ready2),
    .commit(commit), .rd_commit(rd_commit), .rob_entry_commit(rob_entry_commit),
    .commit_value(commit_value)
  );

  typedef struct {
    bit          rst, fl, dv;
    logic [4:0]  drd;
    bit          wv;
    logic [3:0]  wt;
    logic [31:0] wval;
    logic [3:0]  t1, t2;
    logic [3:0]  ein;
    bit          efull, eempty;
    logic [4:0]  erdwb;
    bit          err1;
    logic [31:0] erv1;
    bit          err2;
    logic [31:0] erv2;
    bit          ecm;
    logic [4:0]  erdc;
    logic [3:0]  etagc;
    logic [31:0] ecval;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; flush = v.fl; dispatch_valid = v.dv; dispatch_rd = v.drd;
    valid_wb = v.wv; rob_entry_wb = v.wt; wb_value = v.wval;
    read_tag1 = v.t1; read_tag2 = v.t2;
  endtask

  initial begin
    vec_t idle;
    bit   seen;
    idle = vec_t'{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0};
    drive(idle);

    //           rst fl dv drd wv wt wval    t1 t2 | ein full empty rdwb rr1 rv1   rr2 rv2   cm rdc tagc cval
    tab.push_back(vec_t'{0,0,1,1, 0,0,0,      0,0,   1,0,1, 0, 0,0,     0,0,     0,0,0,0});      // 0
    tab.push_back(vec_t'{0,0,1,2, 0,0,0,      0,0,   2,0,0, 0, 0,0,     0,0,     0,0,0,0});      // 1
    tab.push_back(vec_t'{0,0,1,0, 0,0,0,      0,0,   3,0,0, 0, 0,0,     0,0,     0,0,0,0});      // 2
    tab.push_back(vec_t'{0,0,0,0, 1,2,'h22,   2,0,   4,0,0, 2, 1,'h22,  0,0,     0,0,0,0});      // 3
    tab.push_back(vec_t'{0,0,0,0, 1,1,'h11,   2,1,   4,0,0, 1, 1,'h22,  1,'h11,  0,0,0,0});      // 4
    tab.push_back(vec_t'{0,0,0,0, 0,0,0,      3,0,   4,0,0, 0, 0,0,     0,0,     1,1,1,'h11});   // 5
    tab.push_back(vec_t'{0,0,0,0, 0,0,0,      1,0,   4,0,0, 0, 0,0,     0,0,     1,2,2,'h22});   // 6
    tab.push_back(vec_t'{0,0,0,0, 1,3,'h33,   3,0,   4,0,0, 0, 1,'h33,  0,0,     0,0,0,0});      // 7
    tab.push_back(vec_t'{0,0,0,0, 1,6,'h66,   6,0,   4,0,0, 0, 0,0,     0,0,     1,0,3,'h33});   // 8
    tab.push_back(vec_t'{0,0,0,0, 0,0,0,      6,0,   4,0,1, 0, 0,0,     0,0,     0,0,0,0});      // 9
    tab.push_back(vec_t'{0,0,1,5, 0,0,0,      0,0,   4,0,1, 0, 0,0,     0,0,     0,0,0,0});      // 10
    tab.push_back(vec_t'{0,0,1,6, 0,0,0,      0,0,   5,0,0, 0, 0,0,     0,0,     0,0,0,0});      // 11
    tab.push_back(vec_t'{0,0,1,7, 1,4,'h44,   0,0,   6,0,0, 5, 0,0,     0,0,     0,0,0,0});      // 12
    tab.push_back(vec_t'{0,1,0,0, 1,5,'h55,   4,0,   7,0,0, 6, 1,'h44,  0,0,     0,0,0,0});      // 13 flush
    tab.push_back(vec_t'{0,0,0,0, 1,2,'h99,   2,0,   1,0,1, 0, 0,0,     0,0,     0,0,0,0});      // 14 stale wb
    for (int i = 0; i < 8; i++)                                                                 // 15..22 fill
      tab.push_back(vec_t'{0,0,1,5'(10+i), 0,0,0, 0,0, 4'(1+i),0,(i==0), 0, 0,0, 0,0, 0,0,0,0});
    tab.push_back(vec_t'{0,0,1,20,0+1,1,'ha1, 0,0,   1,1,0,10, 0,0,     0,0,     0,0,0,0});      // 23 full, ignored
    tab.push_back(vec_t'{0,0,1,21, 0,0,0,     0,0,   1,1,0, 0, 0,0,     0,0,     1,10,1,'ha1});  // 24 commit+disp rejected
    tab.push_back(vec_t'{0,0,1,22, 0,0,0,     0,0,   1,0,0, 0, 0,0,     0,0,     0,0,0,0});      // 25 wrap to tag 1
    tab.push_back(vec_t'{0,0,0,0,  0,1,0,     1,0,   2,1,0,22, 0,0,     0,0,     0,0,0,0});      // 26
    tab.push_back(vec_t'{1,0,0,0,  0,0,0,     0,0,   2,1,0, 0, 0,0,     0,0,     0,0,0,0});      // 27 reset mid-stream
    tab.push_back(vec_t'{0,0,0,0,  0,1,0,     1,2,   1,0,1, 0, 0,0,     0,0,     0,0,0,0});      // 28
    tab.push_back(vec_t'{0,0,1,3,  0,0,0,     0,0,   1,0,1, 0, 0,0,     0,0,     0,0,0,0});      // 29
    tab.push_back(vec_t'{0,0,0,0,  0,1,0,     1,0,   2,0,0, 3, 0,0,     0,0,     0,0,0,0});      // 30

    reset = 1'b1;
    repeat (2) @(posedge clock);

    foreach (tab[k]) begin
      @(negedge clock);
      drive(tab[k]);
      #1;
      chk("rob_entry_in", k, 32'(rob_entry_in), 32'(tab[k].ein));
      chk("full", k, 32'(full), 32'(tab[k].efull));
      chk("empty", k, 32'(empty), 32'(tab[k].eempty));
      chk("rd_wb", k, 32'(rd_wb), 32'(tab[k].erdwb));
      chk("read_ready1", k, 32'(read_ready1), 32'(tab[k].err1));
      chk("read_value1", k, read_value1, tab[k].erv1);
      chk("read_ready2", k, 32'(read_ready2), 32'(tab[k].err2));
      chk("read_value2", k, read_value2, tab[k].erv2);
      chk("commit", k, 32'(commit), 32'(tab[k].ecm));
      chk("rd_commit", k, 32'(rd_commit), 32'(tab[k].erdc));
      chk("rob_entry_commit", k, 32'(rob_entry_commit), 32'(tab[k].etagc));
      chk("commit_value", k, commit_value, tab[k].ecval);
      @(posedge clock);
    end

    // Entry 1 (rd 3) is live at the head: writeback must not commit in the same cycle.
    @(negedge clock);
    drive(idle);
    valid_wb = 1'b1; rob_entry_wb = 4'd1; wb_value = 32'h5a;
    #1;
    chk("seq_no_bypass_commit", 100, 32'(commit), 32'd0);
    @(negedge clock);
    drive(idle);
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      #1;
      if (commit) seen = 1'b1;
      else @(negedge clock);
    end
    chk("seq_commit_seen", 101, 32'(seen), 32'd1);
    chk("seq_commit_tag", 102, 32'(rob_entry_commit), 32'd1);
    chk("seq_commit_rd", 103, 32'(rd_commit), 32'd3);
    chk("seq_commit_value", 104, commit_value, 32'h5a);
    @(posedge clock);
    #1;
    chk("seq_empty_after", 105, 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
